reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order retirement queue of the Tomasulo core; the producer of the tags/operands the reservation station consumes.
//  Issue: allocates a tag (newTag) per instruction. Operand query: answers ready/value for renamed sources. Completion: captures ALU/LSB CDB results.
//  Commit: retires the head to regFile/LSB one per cycle; raises flush + redirect PC on branch mispredict.
// PARAMETERS
//  ROB_SIZE   8   entries; power of two
//  ID_WIDTH   4   tag width; tag = slot+1, tag 0 = "no dependency"
//  VAL_WIDTH  32  data / PC width
// PORTS
//  clk          in   1   clock
//  rst_n_in     in   1   async active-low reset
//  rdy_in       in   1   global enable; 0 = hold all state
//  dec2rob_en   in   1   issue request
//  dec_type     in   OP_WIDTH  opcode class (OP_* codes; branch/JALR/store flags derived)
//  dec_rd       in   5   destination register (0 = none)
//  dec_pred_pc  in   32  predicted next PC
//  isFull       out  1   no free slot; issue refused
//  newTag       out  4   tag the current issue receives
//  qry_lab1/2   in   4   source tags from rename table
//  ready1/2     out  1   source value available
//  res1/2       out  32  source value
//  cdb0_en/cdb1_en    in 1   ALU / LSB broadcast valid
//  cdb0_lab/cdb1_lab  in 4   producing tag
//  cdb0_val/cdb1_val  in 32  result value
//  cdb0_pc            in 32  resolved next PC (branch/JALR only)
//  commit_en    out  1   register write pulse
//  commit_rd    out  5   register index
//  commit_val   out  32  write data
//  commit_tag   out  4   retiring tag (regFile clears rename if equal)
//  commit_store out  1   store retire pulse to LSB (tag on commit_tag)
//  flush        out  1   mispredict pulse
//  flush_pc     out  32  redirect target
// BEHAVIOUR
//  Reset (async, rst_n_in=0): all entries invalid; head=tail=count=0; isFull=0; newTag=1; all pulse outputs 0; flush_pc=0.
//  Pointers: 3-bit head/tail wrap modulo ROB_SIZE; count 0..ROB_SIZE. isFull = (count==ROB_SIZE), from registered count only.
//  newTag = tail+1, combinational.
//  Issue (rdy_in & dec2rob_en & !isFull & !flush): slot[tail] <= {busy=1, ready=0, type, rd, pred_pc}; tail++ at the edge.
//  CDB capture: each valid bus whose tag is nonzero and names a busy slot sets ready=1 and val. cdb0 also stores pc.
//   - Tag 0 or non-busy slot is ignored.
//   - Both buses may write different slots in the same cycle.
//  Query: tag 0 -> ready=0, res=0. Otherwise ready/res come from the slot, with same-cycle CDB bypass.
//   - CDB bypass priority: cdb0, then cdb1, then stored value.
//  Commit (rdy_in & head busy & ready & !flush): head cleared, head++. Outputs are registered and valid the cycle after the edge:
//   - store: commit_store=1, commit_en=0.
//   - other: commit_en = (rd!=0), commit_rd/val/tag.
//   - branch/JALR: additionally flush=1, flush_pc=pc when pc != pred_pc.
//  Pulses last one cycle. All pulses are 0 in any cycle following an edge with rdy_in=0.
//  Issue+commit in the same cycle: count unchanged. Full+commit: issue still refused that cycle.
//  Flush (flush=1 & rdy_in): at that edge all slots invalid, head=tail=count=0; issue and CDB are ignored.
//   - newTag returns to 1 after the flush edge.
//   - The mispredicting branch has already retired (its link write goes out with the flush).
//  Reset mid-operation: immediate clear regardless of clk/rdy_in.
// STRUCTURE
//  Shared header (defines.v): ROB_SIZE, ID_WIDTH, VAL_WIDTH, OP_WIDTH, OP_* codes, is_branch/is_store helpers.
//  Sub-module rob_operand_lookup: combinational tag->{ready,val} with CDB bypass; instantiated twice (src1, src2).
//  Top: pointer/count logic, entry arrays, commit/flush output registers.
// TESTING
//  1. Reset, then issue 3 ALU ops rd=1,2,3. Expect newTag 1,2,3.
//     cdb0 tag2=0x22 then tag1=0x11, then tag3=0x33.
//     Expect commits in order rd1=0x11, rd2=0x22, rd3=0x33 on 3 consecutive cycles.
//  2. Issue 8 ops: isFull=1 and the 9th request is ignored.
//     Complete tag1 and retire it in the same cycle as a new request: request refused.
//     Next cycle: accepted with newTag=1 (wrap).
//  3. Query qry_lab1=2 while cdb1 tag2=0xABCD in the same cycle: ready1=1, res1=0xABCD.
//     qry_lab1=0: ready1=0.
//  4. Branch pred_pc=0x104, cdb0 pc=0x200.
//     At commit: flush=1, flush_pc=0x200.
//     The next cycle the ROB is empty, newTag=1, and younger CDB writes are ignored.
//  5. Store entry completes via cdb1: commit_store=1, commit_en=0. rd=0 ALU op retires with commit_en=0.
//  6. Hold rdy_in=0 with a ready head: no commit, state frozen.
//     Assert rst_n_in mid-sequence: outputs return to reset values immediately.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared parameters, opcode classes and helpers for the reorder buffer.
// Tags are slot+1 so that tag 0 can mean "no dependency".
package reorder_buffer_pkg;

   localparam int ROB_SIZE  = 8;
   localparam int ID_WIDTH  = 4;
   localparam int VAL_WIDTH = 32;
   localparam int OP_WIDTH  = 3;
   localparam int PTR_W     = $clog2(ROB_SIZE);
   localparam int CNT_W     = PTR_W + 1;

   typedef logic [PTR_W-1:0] ptr_t;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_ALU    = 3'd0,
      OP_LOAD   = 3'd1,
      OP_STORE  = 3'd2,
      OP_BRANCH = 3'd3,
      OP_JAL    = 3'd4,
      OP_JALR   = 3'd5
   } op_e;

   // Only conditional branches and JALR resolve their target late.
   function automatic logic is_branch(input logic [OP_WIDTH-1:0] op);
      return (op == OP_BRANCH) || (op == OP_JALR);
   endfunction

   function automatic logic is_store(input logic [OP_WIDTH-1:0] op);
      return op == OP_STORE;
   endfunction

   function automatic ptr_t tag_to_slot(input logic [ID_WIDTH-1:0] tag);
      return ptr_t'(tag - ID_WIDTH'(1));
   endfunction

endpackage

// File: rtl/rob_operand_lookup.sv
// Combinational tag -> {ready, value} lookup with same-cycle CDB bypass.
// Priority: cdb0, then cdb1, then the stored entry.
module rob_operand_lookup
   import reorder_buffer_pkg::*;
(
   input  logic [ID_WIDTH-1:0]  tag,
   input  logic [ROB_SIZE-1:0]  ready_vec,
   input  logic [VAL_WIDTH-1:0] val_arr [ROB_SIZE],
   input  logic                 cdb0_en,
   input  logic [ID_WIDTH-1:0]  cdb0_lab,
   input  logic [VAL_WIDTH-1:0] cdb0_val,
   input  logic                 cdb1_en,
   input  logic [ID_WIDTH-1:0]  cdb1_lab,
   input  logic [VAL_WIDTH-1:0] cdb1_val,
   output logic                 ready,
   output logic [VAL_WIDTH-1:0] res
);

   ptr_t slot;

   // NOTE: every output gets a default first, so no path can infer a latch.
   always_comb begin
      ready = 1'b0;
      res   = '0;
      slot  = tag_to_slot(tag);
      if (tag != '0) begin
         if (cdb0_en && cdb0_lab == tag) begin
            ready = 1'b1;
            res   = cdb0_val;
         end else if (cdb1_en && cdb1_lab == tag) begin
            ready = 1'b1;
            res   = cdb1_val;
         end else if (ready_vec[slot]) begin
            ready = 1'b1;
            res   = val_arr[slot];
         end
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates tags at issue, captures CDB
// results, answers operand queries and retires the head with mispredict flush.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n_in,
   input  logic                 rdy_in,
   input  logic                 dec2rob_en,
   input  logic [OP_WIDTH-1:0]  dec_type,
   input  logic [4:0]           dec_rd,
   input  logic [VAL_WIDTH-1:0] dec_pred_pc,
   output logic                 isFull,
   output logic [ID_WIDTH-1:0]  newTag,
   input  logic [ID_WIDTH-1:0]  qry_lab1,
   input  logic [ID_WIDTH-1:0]  qry_lab2,
   output logic                 ready1,
   output logic                 ready2,
   output logic [VAL_WIDTH-1:0] res1,
   output logic [VAL_WIDTH-1:0] res2,
   input  logic                 cdb0_en,
   input  logic [ID_WIDTH-1:0]  cdb0_lab,
   input  logic [VAL_WIDTH-1:0] cdb0_val,
   input  logic [VAL_WIDTH-1:0] cdb0_pc,
   input  logic                 cdb1_en,
   input  logic [ID_WIDTH-1:0]  cdb1_lab,
   input  logic [VAL_WIDTH-1:0] cdb1_val,
   output logic                 commit_en,
   output logic [4:0]           commit_rd,
   output logic [VAL_WIDTH-1:0] commit_val,
   output logic [ID_WIDTH-1:0]  commit_tag,
   output logic                 commit_store,
   output logic                 flush,
   output logic [VAL_WIDTH-1:0] flush_pc
);

   logic [ROB_SIZE-1:0]  busy, ready;
   logic [VAL_WIDTH-1:0] val_q  [ROB_SIZE];
   logic [VAL_WIDTH-1:0] pc_q   [ROB_SIZE];
   logic [VAL_WIDTH-1:0] pred_q [ROB_SIZE];
   logic [4:0]           rd_q   [ROB_SIZE];
   logic [OP_WIDTH-1:0]  type_q [ROB_SIZE];
   ptr_t                 head, tail, slot0, slot1;
   logic [CNT_W-1:0]     count;
   logic                 do_issue, do_commit, cdb0_hit, cdb1_hit;

   assign isFull = (count == CNT_W'(ROB_SIZE));
   assign newTag = ID_WIDTH'(tail) + ID_WIDTH'(1);

   // While a flush is pending, issue, CDB capture and commit are all ignored.
   assign slot0     = tag_to_slot(cdb0_lab);
   assign slot1     = tag_to_slot(cdb1_lab);
   assign cdb0_hit  = rdy_in && !flush && cdb0_en && cdb0_lab != '0 && busy[slot0];
   assign cdb1_hit  = rdy_in && !flush && cdb1_en && cdb1_lab != '0 && busy[slot1];
   assign do_issue  = rdy_in && dec2rob_en && !isFull && !flush;
   assign do_commit = rdy_in && busy[head] && ready[head] && !flush;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy  <= '0;
         ready <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rdy_in) begin
         if (flush) begin
            busy  <= '0;
            ready <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (cdb0_hit) ready[slot0] <= 1'b1;
            if (cdb1_hit) ready[slot1] <= 1'b1;
            if (do_issue) begin
               busy[tail]  <= 1'b1;
               ready[tail] <= 1'b0;
               tail        <= tail + PTR_W'(1);
            end
            if (do_commit) begin
               busy[head]  <= 1'b0;
               ready[head] <= 1'b0;
               head        <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(do_issue) - CNT_W'(do_commit);
         end
      end
   end

   // NOTE: payload arrays have no reset; busy/ready gate every read of them.
   always_ff @(posedge clk) begin
      if (cdb0_hit) begin
         val_q[slot0] <= cdb0_val;
         pc_q[slot0]  <= cdb0_pc;
      end
      if (cdb1_hit) val_q[slot1] <= cdb1_val;
      if (do_issue) begin
         type_q[tail] <= dec_type;
         rd_q[tail]   <= dec_rd;
         pred_q[tail] <= dec_pred_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         commit_en    <= 1'b0;
         commit_store <= 1'b0;
         flush        <= 1'b0;
         commit_rd    <= '0;
         commit_val   <= '0;
         commit_tag   <= '0;
         flush_pc     <= '0;
      end else begin
         commit_en    <= 1'b0;
         commit_store <= 1'b0;
         flush        <= 1'b0;
         if (do_commit) begin
            commit_rd  <= rd_q[head];
            commit_val <= val_q[head];
            commit_tag <= ID_WIDTH'(head) + ID_WIDTH'(1);
            if (is_store(type_q[head])) commit_store <= 1'b1;
            else                        commit_en    <= (rd_q[head] != '0);
            if (is_branch(type_q[head]) && pc_q[head] != pred_q[head]) begin
               flush    <= 1'b1;
               flush_pc <= pc_q[head];
            end
         end
      end
   end

   rob_operand_lookup u_lookup_src1 (
      .tag       (qry_lab1),
      .ready_vec (ready),
      .val_arr   (val_q),
      .cdb0_en   (cdb0_en),
      .cdb0_lab  (cdb0_lab),
      .cdb0_val  (cdb0_val),
      .cdb1_en   (cdb1_en),
      .cdb1_lab  (cdb1_lab),
      .cdb1_val  (cdb1_val),
      .ready     (ready1),
      .res       (res1)
   );

   rob_operand_lookup u_lookup_src2 (
      .tag       (qry_lab2),
      .ready_vec (ready),
      .val_arr   (val_q),
      .cdb0_en   (cdb0_en),
      .cdb0_lab  (cdb0_lab),
      .cdb0_val  (cdb0_val),
      .cdb1_en   (cdb1_en),
      .cdb1_lab  (cdb1_lab),
      .cdb1_val  (cdb1_val),
      .ready     (ready2),
      .res       (res2)
   );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: ordering, full/wrap,
// operand bypass, mispredict flush, store retire, stall and async reset.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n_in, rdy_in, dec2rob_en;
   logic [2:0]  dec_type;
   logic [4:0]  dec_rd;
   logic [31:0] dec_pred_pc;
   logic        isFull;
   logic [3:0]  newTag, qry_lab1, qry_lab2;
   logic        ready1, ready2;
   logic [31:0] res1, res2;
   logic        cdb0_en, cdb1_en;
   logic [3:0]  cdb0_lab, cdb1_lab;
   logic [31:0] cdb0_val, cdb0_pc, cdb1_val;
   logic        commit_en, commit_store, flush;
   logic [4:0]  commit_rd;
   logic [31:0] commit_val, flush_pc;
   logic [3:0]  commit_tag;

   int checks = 0;
   int errors = 0;

   reorder_buffer dut (
      .clk(clk), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .dec2rob_en(dec2rob_en), .dec_type(dec_type), .dec_rd(dec_rd), .dec_pred_pc(dec_pred_pc),
      .isFull(isFull), .newTag(newTag),
      .qry_lab1(qry_lab1), .qry_lab2(qry_lab2),
      .ready1(ready1), .ready2(ready2), .res1(res1), .res2(res2),
      .cdb0_en(cdb0_en), .cdb0_lab(cdb0_lab), .cdb0_val(cdb0_val), .cdb0_pc(cdb0_pc),
      .cdb1_en(cdb1_en), .cdb1_lab(cdb1_lab), .cdb1_val(cdb1_val),
      .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
      .commit_tag(commit_tag), .commit_store(commit_store),
      .flush(flush), .flush_pc(flush_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      dec2rob_en = 1'b0; dec_type = OP_ALU; dec_rd = '0; dec_pred_pc = '0;
      qry_lab1 = '0; qry_lab2 = '0;
      cdb0_en = 1'b0; cdb0_lab = '0; cdb0_val = '0; cdb0_pc = '0;
      cdb1_en = 1'b0; cdb1_lab = '0; cdb1_val = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_n_in = 1'b0;
      tick();
      rst_n_in = 1'b1;
   endtask

   task automatic issue_op(input logic [2:0] t, input logic [4:0] rd,
                           input logic [31:0] pred, input logic [3:0] exp_tag);
      dec2rob_en = 1'b1; dec_type = t; dec_rd = rd; dec_pred_pc = pred;
      #1 check("issue_newTag", newTag, exp_tag);
      tick();
      dec2rob_en = 1'b0;
   endtask

   task automatic cdb0(input logic [3:0] lab, input logic [31:0] val, input logic [31:0] pc);
      cdb0_en = 1'b1; cdb0_lab = lab; cdb0_val = val; cdb0_pc = pc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rdy_in = 1'b1;
      idle();
      rst_n_in = 1'b0;
      #3;
      check("rst_isFull", isFull, 0);
      check("rst_newTag", newTag, 1);
      check("rst_commit_en", commit_en, 0);
      check("rst_flush", flush, 0);
      check("rst_flush_pc", flush_pc, 0);
      tick();
      rst_n_in = 1'b1;

      // In-order retirement despite out-of-order completion
      issue_op(OP_ALU, 5'd1, 32'h0, 4'd1);
      issue_op(OP_ALU, 5'd2, 32'h0, 4'd2);
      issue_op(OP_ALU, 5'd3, 32'h0, 4'd3);
      cdb0(4'd2, 32'h22, 32'h0); tick();
      cdb0(4'd1, 32'h11, 32'h0); tick();
      check("early_commit", commit_en, 0);
      cdb0(4'd3, 32'h33, 32'h0); tick();
      cdb0_en = 1'b0;
      check("c1_en", commit_en, 1);  check("c1_rd", commit_rd, 1);
      check("c1_val", commit_val, 32'h11); check("c1_tag", commit_tag, 1);
      tick();
      check("c2_en", commit_en, 1);  check("c2_rd", commit_rd, 2);
      check("c2_val", commit_val, 32'h22);
      tick();
      check("c3_en", commit_en, 1);  check("c3_rd", commit_rd, 3);
      check("c3_val", commit_val, 32'h33);
      tick();
      check("c_idle", commit_en, 0);

      // Fill, refuse when full, commit+issue same cycle, wrap to tag 1
      do_reset();
      dec2rob_en = 1'b1; dec_type = OP_ALU; dec_rd = 5'd6;
      for (int i = 0; i < 8; i++) begin
         #1 check("fill_newTag", newTag, 32'(i + 1));
         tick();
      end
      check("full", isFull, 1);
      check("full_newTag", newTag, 1);
      tick();
      check("ninth_refused_full", isFull, 1);
      check("ninth_refused_tag", newTag, 1);
      cdb0(4'd1, 32'h55, 32'h0); tick();
      cdb0_en = 1'b0;
      check("full_before_commit", isFull, 1);
      tick();
      check("wrap_commit_en", commit_en, 1);
      check("wrap_commit_tag", commit_tag, 1);
      check("wrap_commit_val", commit_val, 32'h55);
      check("issue_refused_isFull", isFull, 0);
      check("wrap_newTag", newTag, 1);
      tick();
      dec2rob_en = 1'b0;
      check("wrap_accept_full", isFull, 1);
      check("wrap_accept_newTag", newTag, 2);

      // Operand query with bypass
      qry_lab1 = 4'd2;
      cdb1_en = 1'b1; cdb1_lab = 4'd2; cdb1_val = 32'hABCD;
      #1 check("byp_ready1", ready1, 1);
      check("byp_res1", res1, 32'hABCD);
      cdb0(4'd3, 32'h3333, 32'h0); cdb1_lab = 4'd3; cdb1_val = 32'h4444; qry_lab2 = 4'd3;
      #1 check("byp_prio_res2", res2, 32'h3333);
      cdb1_lab = 4'd2; cdb1_val = 32'hABCD; cdb0_en = 1'b0;
      #1 check("pending_ready2", ready2, 0);
      tick();
      cdb1_en = 1'b0; qry_lab2 = 4'd2;
      #1 check("stored_ready2", ready2, 1);
      check("stored_res2", res2, 32'hABCD);
      qry_lab1 = 4'd0;
      #1 check("tag0_ready1", ready1, 0);
      check("tag0_res1", res1, 0);

      // Mispredicted branch flushes; younger CDB and issue are ignored
      do_reset();
      issue_op(OP_BRANCH, 5'd0, 32'h104, 4'd1);
      issue_op(OP_ALU, 5'd7, 32'h0, 4'd2);
      cdb0(4'd1, 32'h0, 32'h200); tick();
      cdb0_en = 1'b0;
      tick();
      check("br_flush", flush, 1);
      check("br_flush_pc", flush_pc, 32'h200);
      check("br_commit_en", commit_en, 0);
      cdb0(4'd2, 32'h77, 32'h0);
      dec2rob_en = 1'b1; dec_type = OP_ALU; dec_rd = 5'd9;
      tick();
      idle();
      qry_lab1 = 4'd2;
      #1 check("post_flush_flush", flush, 0);
      check("post_flush_newTag", newTag, 1);
      check("post_flush_isFull", isFull, 0);
      check("younger_cdb_ignored", ready1, 0);
      tick();
      check("post_flush_no_commit", commit_en, 0);
      issue_op(OP_BRANCH, 5'd0, 32'h300, 4'd1);
      cdb0(4'd1, 32'h0, 32'h300); tick();
      cdb0_en = 1'b0;
      tick();
      check("good_pred_no_flush", flush, 0);
      check("good_pred_tag", commit_tag, 1);

      // Store retire and rd=0 ALU op
      do_reset();
      issue_op(OP_STORE, 5'd0, 32'h0, 4'd1);
      issue_op(OP_ALU, 5'd0, 32'h0, 4'd2);
      cdb1_en = 1'b1; cdb1_lab = 4'd1; cdb1_val = 32'h9;
      cdb0(4'd2, 32'h5, 32'h0);
      tick();
      idle();
      tick();
      check("st_commit_store", commit_store, 1);
      check("st_commit_en", commit_en, 0);
      check("st_commit_tag", commit_tag, 1);
      tick();
      check("rd0_commit_store", commit_store, 0);
      check("rd0_commit_en", commit_en, 0);
      check("rd0_commit_tag", commit_tag, 2);

      // Stall with rdy_in=0, then async reset mid-cycle
      issue_op(OP_ALU, 5'd4, 32'h0, 4'd3);
      cdb0(4'd3, 32'h44, 32'h0); tick();
      cdb0_en = 1'b0;
      rdy_in = 1'b0;
      dec2rob_en = 1'b1;
      tick();
      check("stall_commit_en", commit_en, 0);
      check("stall_commit_tag", commit_tag, 2);
      tick();
      check("stall_newTag", newTag, 4);
      check("stall_commit_en2", commit_en, 0);
      dec2rob_en = 1'b0;
      rdy_in = 1'b1;
      tick();
      check("resume_commit_en", commit_en, 1);
      check("resume_commit_rd", commit_rd, 4);
      check("resume_commit_val", commit_val, 32'h44);
      check("resume_commit_tag", commit_tag, 3);
      #1 rst_n_in = 1'b0;
      #1 check("async_rst_commit_en", commit_en, 0);
      check("async_rst_commit_tag", commit_tag, 0);
      check("async_rst_newTag", newTag, 1);
      check("async_rst_isFull", isFull, 0);
      tick();
      rst_n_in = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
